mem_port_arbiter: RTL and testbench

- Shares one single-port memory (req/ready handshake, variable latency) between the CPU instruction-fetch port and the CPU data load/store port.
- Sits between the CPU top level (Instr_Addr, MEM_addr, MEM_WR_out, MEM_type, MEM_rd_en, MEM_wr_en) and the memory.
- Arbitrates between the two ports, sequences each transaction, returns read data with a one-cycle ack, and drives a pipeline stall while either request is outstanding.

---
 rtl/mem_port_arbiter_if.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the CPU fetch port, the CPU data port and the
// single-port memory bus that mem_port_arbiter sits between.
//
// Handshake semantics (one place for all of them):
//   - if_req / (dm_rd_en | dm_wr_en) are held high by the CPU until the
//     matching one-cycle if_ack / dm_ack pulse. Address and data are held
//     with the request. In the ack cycle the request may drop or change.
//   - mem_req is held high with a stable command until mem_ready = 1.
//     mem_rdata is valid only in that cycle. mem_ready outside an
//     outstanding mem_req is ignored.
//   - if_rdata / dm_rdata are valid with their ack and hold until the next
//     ack of the same kind.
interface mem_port_arbiter_if;
  // CPU instruction-fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  // CPU data load/store port
  logic        dm_rd_en;
  logic        dm_wr_en;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_type;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  // memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_type;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  // status
  logic        cpu_stall;
  logic        err_timeout;

  // Arbiter view
  modport slave (
    input  if_req, if_addr,
    input  dm_rd_en, dm_wr_en, dm_addr, dm_wdata, dm_type,
    input  mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_type,
    output cpu_stall, err_timeout
  );

  // Environment view (CPU plus memory)
  modport master (
    output if_req, if_addr,
    output dm_rd_en, dm_wr_en, dm_addr, dm_wdata, dm_type,
    output mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_type,
    input  cpu_stall, err_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency memory between
// the CPU fetch port and the CPU data port. IDLE picks a winner and registers
// the command, BUSY holds mem_req until mem_ready, RESP pulses the owner's
// ack for one cycle. Data wins by default; fetch is forced after FAIR_LIMIT
// consecutive data grants made while a fetch was waiting.
//
// Optional build macro ARB_TIMEOUT_EN: when defined, a BUSY access that sees
// no mem_ready for TIMEOUT cycles is aborted, acked with zero read data, and
// the sticky err_timeout flag is set. When undefined BUSY waits forever and
// err_timeout stays 0.
module mem_port_arbiter #(
  parameter int unsigned FAIR_LIMIT = 4,   // 1..15
  parameter int unsigned TIMEOUT    = 64   // 2..255, only with ARB_TIMEOUT_EN
) (
  input  logic                CLK,
  input  logic                Reset,
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          dbg_state_o,
  output logic [3:0]          dbg_starve_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] FairLim = 4'(FAIR_LIMIT);
  localparam logic [2:0] FetchType = 3'b010;

  state_t      state_q;
  logic        owner_dm_q;     // 1 = data port owns the access, 0 = fetch
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [2:0]  mem_type_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        if_ack_q;
  logic        dm_ack_q;
  logic [3:0]  starve_q;
  logic        err_q;

  logic        dm_any;
  logic        grant_if_d;
  logic [3:0]  starve_d;
  logic        tmo_hit;

  assign dm_any = bus.dm_rd_en | bus.dm_wr_en;

  // Winner selection and starvation bookkeeping for the next IDLE grant
  always_comb begin
    grant_if_d = bus.if_req & (~dm_any | (starve_q == FairLim));
    starve_d   = starve_q;
    if (grant_if_d) begin
      starve_d = 4'd0;
    end else if (bus.if_req && (starve_q != FairLim)) begin
      starve_d = starve_q + 4'd1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  logic [7:0] tmo_q;

  // Count BUSY cycles without mem_ready; cleared whenever BUSY is left
  always_ff @(posedge CLK) begin
    if (Reset) begin
      tmo_q <= 8'd0;
    end else if ((state_q == BUSY) && !bus.mem_ready && !tmo_hit) begin
      tmo_q <= tmo_q + 8'd1;
    end else begin
      tmo_q <= 8'd0;
    end
  end

  assign tmo_hit = (state_q == BUSY) & ~bus.mem_ready & (tmo_q == TmoLast);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  // Main sequencer with registered memory command, read data and acks
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      owner_dm_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_type_q  <= 3'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      starve_q    <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.if_req || dm_any) begin
            state_q    <= BUSY;
            mem_req_q  <= 1'b1;
            starve_q   <= starve_d;
            owner_dm_q <= ~grant_if_d;
            if (grant_if_d) begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= bus.if_addr;
              mem_wdata_q <= 32'd0;
              mem_type_q  <= FetchType;
            end else begin
              // A simultaneous load+store is a store
              mem_we_q    <= bus.dm_wr_en;
              mem_addr_q  <= bus.dm_addr;
              mem_wdata_q <= bus.dm_wdata;
              mem_type_q  <= bus.dm_type;
            end
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            if (owner_dm_q) begin
              dm_ack_q <= 1'b1;
              if (!mem_we_q) begin
                dm_rdata_q <= bus.mem_rdata;
              end
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end else if (tmo_hit) begin
            // Abandon the access and complete it with zero data
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            if (owner_dm_q) begin
              dm_ack_q <= 1'b1;
              if (!mem_we_q) begin
                dm_rdata_q <= 32'd0;
              end
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= 32'd0;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_type    = mem_type_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.if_ack      = if_ack_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.dm_ack      = dm_ack_q;
  assign bus.err_timeout = err_q;

  // Stall while either port has a request that is not being acked this cycle
  assign bus.cpu_stall = (bus.if_req & ~if_ack_q) | (dm_any & ~dm_ack_q);

  assign dbg_state_o  = state_q;
  assign dbg_starve_o = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. A small memory
// responder answers mem_req after mem_delay cycles with address-derived data
// and logs every grant; the directed sequence compares against hand-computed
// values with immediate assertions.
module tb_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  logic [1:0] dbg_state;
  logic [3:0] dbg_starve;

  mem_port_arbiter #(.FAIR_LIMIT(4), .TIMEOUT(64)) dut (
    .CLK          (clk),
    .Reset        (rst),
    .bus          (bus.slave),
    .dbg_state_o  (dbg_state),
    .dbg_starve_o (dbg_starve)
  );

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- memory responder ----------------
  logic        mem_auto  = 1'b1;
  logic        mem_force = 1'b0;
  int          mem_delay = 1;
  int          req_cyc   = 0;
  logic        auto_ready = 1'b0;
  logic [31:0] auto_rdata = 32'hDEAD_BEEF;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  assign bus.mem_ready = mem_force | auto_ready;
  assign bus.mem_rdata = auto_rdata;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    if (a == 32'h0000_2000) return 32'hCAFE_F00D;
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] grant_code(input logic we, input logic [3:0] st,
                                             input logic [31:0] a);
    return {we, 3'b000, st, a[23:0]};
  endfunction

  always @(negedge clk) begin
    if (bus.mem_req) req_cyc = req_cyc + 1;
    else             req_cyc = 0;
    if (bus.mem_req && req_cyc == 1)
      got_q.push_back(grant_code(bus.mem_we, dbg_starve, bus.mem_addr));
    auto_ready = mem_auto && bus.mem_req && (req_cyc == mem_delay);
    auto_rdata = auto_ready ? mem_model(bus.mem_addr) : 32'hDEAD_BEEF;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n_dack;
    int busy_n;
    int n_ack;
    logic done;
    logic got_ack;

    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'd0;
    bus.dm_rd_en = 1'b0;
    bus.dm_wr_en = 1'b0;
    bus.dm_addr  = 32'd0;
    bus.dm_wdata = 32'd0;
    bus.dm_type  = 3'd0;
    tick();
    tick();

    // reset values
    chk("rst_state",  32'(dbg_state), 32'd0);
    chk("rst_req",    32'(bus.mem_req), 32'd0);
    chk("rst_we",     32'(bus.mem_we), 32'd0);
    chk("rst_if_ack", 32'(bus.if_ack), 32'd0);
    chk("rst_dm_ack", 32'(bus.dm_ack), 32'd0);
    chk("rst_err",    32'(bus.err_timeout), 32'd0);
    chk("rst_addr",   bus.mem_addr, 32'd0);
    chk("rst_wdata",  bus.mem_wdata, 32'd0);
    chk("rst_type",   32'(bus.mem_type), 32'd0);
    chk("rst_ifrd",   bus.if_rdata, 32'd0);
    chk("rst_dmrd",   bus.dm_rdata, 32'd0);
    chk("rst_starve", 32'(dbg_starve), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_stay", 32'(dbg_state), 32'd0);

    // single fetch, minimum latency
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    tick();
    chk("f_state",  32'(dbg_state), 32'd1);
    chk("f_req",    32'(bus.mem_req), 32'd1);
    chk("f_addr",   bus.mem_addr, 32'h100);
    chk("f_we",     32'(bus.mem_we), 32'd0);
    chk("f_type",   32'(bus.mem_type), 32'd2);
    chk("f_stall",  32'(bus.cpu_stall), 32'd1);
    tick();
    chk("f_ack",    32'(bus.if_ack), 32'd1);
    chk("f_rdata",  bus.if_rdata, 32'h0050_0093);
    chk("f_resp",   32'(dbg_state), 32'd2);
    chk("f_req0",   32'(bus.mem_req), 32'd0);
    chk("f_stall0", 32'(bus.cpu_stall), 32'd0);
    bus.if_req = 1'b0;
    tick();
    chk("f_ack0",   32'(bus.if_ack), 32'd0);
    chk("f_idle",   32'(dbg_state), 32'd0);

    // simultaneous fetch and load: data first
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h104;
    bus.dm_rd_en = 1'b1;
    bus.dm_addr  = 32'h2000;
    bus.dm_type  = 3'b100;
    tick();
    chk("s_addr",   bus.mem_addr, 32'h2000);
    chk("s_we",     32'(bus.mem_we), 32'd0);
    chk("s_type",   32'(bus.mem_type), 32'd4);
    chk("s_starve", 32'(dbg_starve), 32'd1);
    chk("s_stall1", 32'(bus.cpu_stall), 32'd1);
    tick();
    chk("s_dack",   32'(bus.dm_ack), 32'd1);
    chk("s_iack0",  32'(bus.if_ack), 32'd0);
    chk("s_dmrd",   bus.dm_rdata, 32'hCAFE_F00D);
    chk("s_stall2", 32'(bus.cpu_stall), 32'd1);
    bus.dm_rd_en = 1'b0;
    tick();
    chk("s_idle",   32'(dbg_state), 32'd0);
    chk("s_dack0",  32'(bus.dm_ack), 32'd0);
    chk("s_stall3", 32'(bus.cpu_stall), 32'd1);
    tick();
    chk("s_faddr",  bus.mem_addr, 32'h104);
    chk("s_ftype",  32'(bus.mem_type), 32'd2);
    chk("s_fstv",   32'(dbg_starve), 32'd0);
    tick();
    chk("s_iack",   32'(bus.if_ack), 32'd1);
    chk("s_ifrd",   bus.if_rdata, 32'hA5A5_0104);
    chk("s_stall4", 32'(bus.cpu_stall), 32'd0);
    bus.if_req = 1'b0;
    tick();

    // fairness: six held stores against a pending fetch
    got_q.delete();
    bus.dm_wr_en = 1'b1;
    bus.dm_addr  = 32'h3000;
    bus.dm_wdata = 32'h1000;
    bus.dm_type  = 3'b010;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h200;
    n_dack = 0;
    done   = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      tick();
      if (bus.dm_ack) begin
        n_dack++;
        bus.dm_addr = bus.dm_addr + 32'd4;
        if (n_dack == 6) bus.dm_wr_en = 1'b0;
      end
      if (bus.if_ack) bus.if_req = 1'b0;
      if (n_dack == 6 && !bus.if_req) done = 1'b1;
    end
    chk("fair_done", 32'(done), 32'd1);
    exp_q.delete();
    exp_q.push_back(grant_code(1'b1, 4'd1, 32'h3000));
    exp_q.push_back(grant_code(1'b1, 4'd2, 32'h3004));
    exp_q.push_back(grant_code(1'b1, 4'd3, 32'h3008));
    exp_q.push_back(grant_code(1'b1, 4'd4, 32'h300C));
    exp_q.push_back(grant_code(1'b0, 4'd0, 32'h0200));
    exp_q.push_back(grant_code(1'b1, 4'd0, 32'h3010));
    exp_q.push_back(grant_code(1'b1, 4'd0, 32'h3014));
    chk("fair_count", 32'(got_q.size()), 32'd7);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("fair_grant%0d", i),
          (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF, exp_q[i]);
    end
    tick();

    // slow store: command held stable for six mem_req cycles
    mem_delay    = 6;
    bus.dm_wr_en = 1'b1;
    bus.dm_addr  = 32'h5000;
    bus.dm_wdata = 32'h1234_5678;
    bus.dm_type  = 3'b000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("w_req",   32'(bus.mem_req), 32'd1);
      chk("w_wdata", bus.mem_wdata, 32'h1234_5678);
      chk("w_type",  32'(bus.mem_type), 32'd0);
      chk("w_we",    32'(bus.mem_we), 32'd1);
      chk("w_noack", 32'(bus.dm_ack), 32'd0);
    end
    tick();
    chk("w_ack",   32'(bus.dm_ack), 32'd1);
    chk("w_req0",  32'(bus.mem_req), 32'd0);
    chk("w_dmrd",  bus.dm_rdata, 32'hCAFE_F00D);
    bus.dm_wr_en = 1'b0;
    mem_delay    = 1;
    tick();

    // load and store together: one store
    bus.dm_rd_en = 1'b1;
    bus.dm_wr_en = 1'b1;
    bus.dm_addr  = 32'h4000;
    bus.dm_wdata = 32'h0000_55AA;
    tick();
    chk("rw_we",    32'(bus.mem_we), 32'd1);
    chk("rw_wdata", bus.mem_wdata, 32'h0000_55AA);
    tick();
    chk("rw_ack",   32'(bus.dm_ack), 32'd1);
    chk("rw_dmrd",  bus.dm_rdata, 32'hCAFE_F00D);
    bus.dm_rd_en = 1'b0;
    bus.dm_wr_en = 1'b0;
    tick();
    chk("rw_ack0",  32'(bus.dm_ack), 32'd0);
    tick();
    chk("rw_idle",  32'(dbg_state), 32'd0);
    chk("rw_req0",  32'(bus.mem_req), 32'd0);

    // reset while BUSY, then stray mem_ready
    mem_auto     = 1'b0;
    bus.dm_rd_en = 1'b1;
    bus.dm_addr  = 32'h40;
    tick();
    tick();
    chk("r_busy",   32'(dbg_state), 32'd1);
    chk("r_req",    32'(bus.mem_req), 32'd1);
    rst          = 1'b1;
    bus.dm_rd_en = 1'b0;
    tick();
    chk("r_state",  32'(dbg_state), 32'd0);
    chk("r_req0",   32'(bus.mem_req), 32'd0);
    chk("r_ack0",   32'(bus.dm_ack), 32'd0);
    chk("r_addr0",  bus.mem_addr, 32'd0);
    chk("r_dmrd0",  bus.dm_rdata, 32'd0);
    rst       = 1'b0;
    mem_force = 1'b1;
    n_ack     = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.dm_ack || bus.if_ack) n_ack++;
      chk("r_ignore", 32'(dbg_state), 32'd0);
    end
    chk("r_noack", 32'(n_ack), 32'd0);
    mem_force = 1'b0;

    // memory that never answers
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    busy_n  = 0;
    n_ack   = 0;
    got_ack = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 150 && !got_ack; i++) begin
      tick();
      if (dbg_state == 2'd1) busy_n++;
      if (bus.if_ack) begin
        got_ack = 1'b1;
        chk("t_rdata", bus.if_rdata, 32'd0);
        chk("t_err",   32'(bus.err_timeout), 32'd1);
      end
    end
    bus.if_req = 1'b0;
    chk("t_acked", 32'(got_ack), 32'd1);
    chk("t_busy",  32'(busy_n), 32'd64);
    tick();
    tick();
    tick();
    chk("t_sticky", 32'(bus.err_timeout), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t_errclr", 32'(bus.err_timeout), 32'd0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      if (dbg_state == 2'd1) busy_n++;
      if (bus.if_ack) n_ack++;
    end
    chk("h_busy",  32'(busy_n), 32'd100);
    chk("h_noack", 32'(n_ack), 32'd0);
    chk("h_err",   32'(bus.err_timeout), 32'd0);
    bus.if_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("h_idle",  32'(dbg_state), 32'd0);
`endif
    mem_auto = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
